// File: rtl/vga_sync_gen.sv
// VGA raster timing source: column/row counters, porched sync, active flag.
// Optional frame counter output guarded by `VGA_FRAME_COUNT_EN`.
module vga_sync_gen #(
  parameter int TOTAL_COLS    = 800,
  parameter int TOTAL_ROWS    = 525,
  parameter int ACTIVE_COLS   = 640,
  parameter int ACTIVE_ROWS   = 480,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_PULSE  = 96,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_PULSE  = 2,
  parameter int COUNT_W       = 10
) (
  input  logic               CLK,
  input  logic               i_Reset,
  input  logic               i_Pix_En,
  output logic               o_HSync,
  output logic               o_VSync,
  output logic               o_Active,
  output logic               o_Frame_Start,
  output logic [COUNT_W-1:0] o_Col_Count,
  output logic [COUNT_W-1:0] o_Row_Count
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0]         o_Frame_Count
`endif
);

  localparam logic [COUNT_W-1:0] COL_LAST =
    COUNT_W'(TOTAL_COLS - 1);
  localparam logic [COUNT_W-1:0] ROW_LAST =
    COUNT_W'(TOTAL_ROWS - 1);
  localparam logic [COUNT_W-1:0] ACT_C =
    COUNT_W'(ACTIVE_COLS);
  localparam logic [COUNT_W-1:0] ACT_R =
    COUNT_W'(ACTIVE_ROWS);
  localparam logic [COUNT_W-1:0] HS_BEG =
    COUNT_W'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [COUNT_W-1:0] HS_END =
    COUNT_W'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_PULSE);
  localparam logic [COUNT_W-1:0] VS_BEG =
    COUNT_W'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [COUNT_W-1:0] VS_END =
    COUNT_W'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_PULSE);

  logic               run;
  logic [COUNT_W-1:0] col;
  logic [COUNT_W-1:0] row;
  logic [COUNT_W-1:0] nxt_col;
  logic [COUNT_W-1:0] nxt_row;
  logic               wrap;
  logic               enter;
  logic               hsync;
  logic               vsync;
  logic               active;
  logic               frame_start;

  // Next raster position; idle always resumes at (0,0)
  always_comb begin
    nxt_col = '0;
    nxt_row = '0;
    wrap    = (col == COL_LAST) && (row == ROW_LAST);
    enter   = !run || wrap;
    if (run) begin
      if (col == COL_LAST) begin
        nxt_col = '0;
        nxt_row = (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        nxt_col = col + 1'b1;
        nxt_row = row;
      end
    end
  end

  // Raster state and flags, all decoded from the next position
  always_ff @(posedge CLK) begin
    if (i_Reset) begin
      run         <= 1'b0;
      col         <= '0;
      row         <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      active      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (i_Pix_En) begin
        run         <= 1'b1;
        col         <= nxt_col;
        row         <= nxt_row;
        active      <= (nxt_col < ACT_C) &&
                       (nxt_row < ACT_R);
        hsync       <= !((nxt_col >= HS_BEG) &&
                         (nxt_col < HS_END));
        vsync       <= !((nxt_row >= VS_BEG) &&
                         (nxt_row < VS_END));
        frame_start <= enter;
      end
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_cnt;

  // Counts completed frames; the start-up (0,0) entry is not counted
  always_ff @(posedge CLK) begin
    if (i_Reset) begin
      frame_cnt <= '0;
    end else if (i_Pix_En && run && wrap) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  assign o_Frame_Count = frame_cnt;
`endif

  assign o_HSync       = hsync;
  assign o_VSync       = vsync;
  assign o_Active      = active;
  assign o_Frame_Start = frame_start;
  assign o_Col_Count   = col;
  assign o_Row_Count   = row;

endmodule
